// File: rtl/spi_io_master.sv
// rtl/spi_io_master.sv - byte-wide SPI mode-0 master driving the core IO-controller bus
`timescale 1ns/1ps
module spi_io_master #(
  parameter int unsigned CLK_DIV = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  input  logic       cs_we,
  input  logic [3:0] cs_sel,
  output logic       SPI_SCK,
  output logic       SPI_DI,
  input  logic       SPI_DO,
  output logic       CONF_DATA0,
  output logic       SPI_SS2,
  output logic       SPI_SS3,
  output logic       SPI_SS4
);

  // Below 3 the DO synchronizer leaves no settle cycle before sampling.
  if (CLK_DIV < 3 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("spi_io_master: CLK_DIV must be within 3..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH
  } state_t;

  localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  phase_q;
  logic [2:0]  bit_q;
  logic [6:0]  tx_sr_q;
  logic [7:0]  rx_sr_q;
  logic [7:0]  rx_data_q;
  logic [1:0]  do_sync_q;
  logic        sck_q;
  logic        di_q;
  logic        rx_valid_q;
  logic [3:0]  cs_q;
  logic [3:0]  pend_q;
  logic        pend_valid_q;
  logic        phase_last;
  logic        done;
  logic        cs_req;

  assign phase_last = (phase_q == PHASE_LAST);
  assign done       = (state_q == ST_HIGH) && phase_last && (bit_q == 3'd0);
  // Multi-hot requests are dropped outright, never latched as pending.
  assign cs_req     = cs_we && $onehot0(cs_sel);

  // Next-state decode: each half-period lasts CLK_DIV cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (tx_valid) state_d = ST_LOW;
      ST_LOW:  if (phase_last) state_d = ST_HIGH;
      ST_HIGH: if (phase_last) state_d = (bit_q == 3'd0) ? ST_IDLE : ST_LOW;
      default: state_d = ST_IDLE;
    endcase
  end

  // Two-flop synchronizer for the asynchronous slave data line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) do_sync_q <= 2'b00;
    else          do_sync_q <= {do_sync_q[0], SPI_DO};
  end

  // State, phase timer, registered SCK and the tx/rx shift datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      phase_q    <= 8'd0;
      bit_q      <= 3'd0;
      tx_sr_q    <= 7'd0;
      rx_sr_q    <= 8'd0;
      rx_data_q  <= 8'd0;
      sck_q      <= 1'b0;
      di_q       <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= (state_q == ST_IDLE || state_d != state_q) ? 8'd0 : phase_q + 8'd1;
      sck_q      <= (state_d == ST_HIGH);
      rx_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (tx_valid) begin
            tx_sr_q <= tx_data[6:0];
            di_q    <= tx_data[7];
            bit_q   <= 3'd7;
          end else begin
            di_q    <= 1'b0;
          end
        end
        ST_LOW: begin
          if (phase_last) rx_sr_q <= {rx_sr_q[6:0], do_sync_q[1]};
        end
        ST_HIGH: begin
          if (phase_last) begin
            if (bit_q != 3'd0) begin
              bit_q   <= bit_q - 3'd1;
              di_q    <= tx_sr_q[6];
              tx_sr_q <= {tx_sr_q[5:0], 1'b0};
            end else begin
              di_q       <= 1'b0;
              rx_valid_q <= 1'b1;
              rx_data_q  <= rx_sr_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Select register: immediate when idle, deferred to the completion edge when busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_q         <= 4'b0000;
      pend_q       <= 4'b0000;
      pend_valid_q <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (cs_req) cs_q <= cs_sel;
    end else if (done) begin
      if (cs_req)            cs_q <= cs_sel;
      else if (pend_valid_q) cs_q <= pend_q;
      pend_valid_q <= 1'b0;
    end else if (cs_req) begin
      pend_q       <= cs_sel;
      pend_valid_q <= 1'b1;
    end
  end

  assign tx_ready   = (state_q == ST_IDLE);
  assign busy       = !tx_ready;
  assign rx_valid   = rx_valid_q;
  assign rx_data    = rx_data_q;
  assign SPI_SCK    = sck_q;
  assign SPI_DI     = di_q;
  assign CONF_DATA0 = !cs_q[0];
  assign SPI_SS2    = !cs_q[1];
  assign SPI_SS3    = !cs_q[2];
  assign SPI_SS4    = !cs_q[3];

endmodule
